// File: rtl/cvt_i2f_seq.sv
// Multi-cycle FCVT.S.W / FCVT.S.WU converter: iterative normalisation,
// RISC-V rounding modes and an inexact flag, launched by START and ended by DONE.
module cvt_i2f_seq #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] A,
  input  logic [3:0]  FUNC,
  input  logic [2:0]  RM,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] result,
  output logic        NX
);

  localparam int unsigned W = 32;
  localparam logic [7:0]  EXP_TOP = 8'd158;
  localparam logic [3:0]  FUNC_WU = 4'd9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ABS   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]   state, state_d;
  logic [W-1:0] a_q, a_d;
  logic         sgnd_q, sgnd_d;
  logic [2:0]   rm_q, rm_d;
  logic         sign_q, sign_d;
  logic [W-1:0] mag_q, mag_d;
  logic [7:0]   exp_q, exp_d;
  logic [31:0]  result_d;
  logic         nx_d, busy_d, done_d;

  logic         abs_sign;
  logic [W-1:0] abs_mag;
  logic [W-1:0] norm_mag;
  logic [7:0]   norm_exp;
  logic [22:0]  mant;
  logic         g, s, inc;
  logic [23:0]  mant_sum;
  logic [22:0]  mant_rnd;
  logic [7:0]   exp_rnd;

  // Sign/magnitude of the captured operand; the most negative value maps onto itself.
  always_comb begin
    abs_sign = sgnd_q & a_q[W-1];
    abs_mag  = abs_sign ? (~a_q + 32'd1) : a_q;
  end

  // One normalisation step: a wide shift only when it cannot pass the leading one.
  always_comb begin
    if (mag_q[W-1 -: SHIFT_STEP] == '0) begin
      norm_mag = mag_q << SHIFT_STEP;
      norm_exp = exp_q - 8'(SHIFT_STEP);
    end else begin
      norm_mag = mag_q << 1;
      norm_exp = exp_q - 8'd1;
    end
  end

  // Rounding of the normalised magnitude; a mantissa carry bumps the exponent.
  always_comb begin
    mant = mag_q[30:8];
    g    = mag_q[7];
    s    = |mag_q[6:0];
    case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_q & (g | s);
      3'b011:  inc = ~sign_q & (g | s);
      3'b100:  inc = g;
      default: inc = g & (s | mant[0]);
    endcase
    mant_sum = {1'b0, mant} + 24'(inc);
    mant_rnd = mant_sum[23] ? 23'd0 : mant_sum[22:0];
    exp_rnd  = exp_q + 8'(mant_sum[23]);
  end

  always_comb begin
    state_d  = state;
    a_d      = a_q;
    sgnd_d   = sgnd_q;
    rm_d     = rm_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    result_d = result;
    nx_d     = NX;
    case (state)
      S_IDLE: begin
        if (START) begin
          a_d     = A;
          sgnd_d  = (FUNC != FUNC_WU);
          rm_d    = RM;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        sign_d = abs_sign;
        mag_d  = abs_mag;
        exp_d  = EXP_TOP;
        if (abs_mag == '0) begin
          result_d = 32'd0;
          nx_d     = 1'b0;
          state_d  = S_OUT;
        end else if (abs_mag[W-1]) begin
          state_d = S_ROUND;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        mag_d = norm_mag;
        exp_d = norm_exp;
        if (norm_mag[W-1]) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = {sign_q, exp_rnd, mant_rnd};
        nx_d     = g | s;
        state_d  = S_OUT;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_OUT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      a_q    <= '0;
      sgnd_q <= 1'b0;
      rm_q   <= '0;
      sign_q <= 1'b0;
      mag_q  <= '0;
      exp_q  <= '0;
      result <= '0;
      NX     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_d;
      a_q    <= a_d;
      sgnd_q <= sgnd_d;
      rm_q   <= rm_d;
      sign_q <= sign_d;
      mag_q  <= mag_d;
      exp_q  <= exp_d;
      result <= result_d;
      NX     <= nx_d;
      BUSY   <= busy_d;
      DONE   <= done_d;
    end
  end

endmodule
